multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 94 +++++++++
 rtl/multicycle_ctrl_if.sv | 43 ++++
 rtl/multicycle_ctrl_sat_counter.sv | 33 +++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller.
// Contents:
//   - opcode constants
//   - FSM state encoding
//   - PCSrc and ALUOp codes
//   - helpers that classify an opcode and decode its datapath fields
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd4;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CLS_AL,
        CLS_BR,
        CLS_LS,
        CLS_J,
        CLS_HALT,
        CLS_ILL
    } op_class_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_b;
        logic       ext_sel;
        logic       reg_out;
    } dec_t;

    function automatic op_class_e op_class(input logic [5:0] op);
        op_class_e c;
        case (op)
            OP_ADD, OP_ADDI, OP_SUB, OP_ORI,
            OP_AND, OP_OR, OP_SLL:           c = CLS_AL;
            OP_BEQ:                          c = CLS_BR;
            OP_LW, OP_SW:                    c = CLS_LS;
            OP_J:                            c = CLS_J;
            OP_HALT:                         c = CLS_HALT;
            default:                         c = CLS_ILL;
        endcase
        return c;
    endfunction

    // ext_sel=1 sign-extends the immediate; reg_out=1 writes rd, else rt.
    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_ADD:  d = '{ALU_ADD, 1'b0, 1'b0, 1'b1};
            OP_ADDI: d = '{ALU_ADD, 1'b1, 1'b1, 1'b0};
            OP_SUB:  d = '{ALU_SUB, 1'b0, 1'b0, 1'b1};
            OP_ORI:  d = '{ALU_OR,  1'b1, 1'b0, 1'b0};
            OP_AND:  d = '{ALU_AND, 1'b0, 1'b0, 1'b1};
            OP_OR:   d = '{ALU_OR,  1'b0, 1'b0, 1'b1};
            OP_SLL:  d = '{ALU_SLL, 1'b0, 1'b0, 1'b1};
            OP_SW:   d = '{ALU_ADD, 1'b1, 1'b1, 1'b0};
            OP_LW:   d = '{ALU_ADD, 1'b1, 1'b1, 1'b0};
            OP_BEQ:  d = '{ALU_SUB, 1'b0, 1'b1, 1'b0};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle of controller <-> datapath/memory signals.
//   master: controller side (drives requests, controls, status, counters)
//   slave : datapath side (drives opcode, zero flag, memory ready)
interface multicycle_ctrl_if #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
);
    logic [OP_W-1:0]  opCode;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             dmem_req;
    logic             IRWre;
    logic             PCWre;
    logic             RegWre;
    logic             ALUSrcB;
    logic             ExtSel;
    logic             RegOut;
    logic             DBDataSrc;
    logic             DataMemRW;
    logic [2:0]       ALUOp;
    logic [1:0]       PCSrc;
    logic [3:0]       state;
    logic             halted;
    logic             illegal_op;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opCode, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, IRWre, PCWre, RegWre, ALUSrcB, ExtSel,
               RegOut, DBDataSrc, DataMemRW, ALUOp, PCSrc, state, halted,
               illegal_op, cycle_cnt, instr_cnt
    );

    modport slave (
        output opCode, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, IRWre, PCWre, RegWre, ALUSrcB, ExtSel,
               RegOut, DBDataSrc, DataMemRW, ALUOp, PCSrc, state, halted,
               illegal_op, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/multicycle_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk, reset : clock, async active-high reset (clears count)
//   inc        : increment enable
//   count      : current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit.
// Sequences IF/ID/EXE/MEM/WB, drives the datapath enables, handshakes with the
// instruction and data memories and keeps saturating cycle/instruction counters.
// Ports:
//   clk, reset : clock, async active-high reset
//   bus        : multicycle_ctrl_if master (opcode/flags/ready in; controls,
//                requests, state, status and counters out)
//
// state    | meaning
// ---------+--------------------------------------------------
// IF       | fetch: request imem, latch opcode on imem_ready
// ID       | decode; J and illegal opcodes retire here
// EXE_AL   | ALU operation
// EXE_BR   | branch compare, PC update from zero flag
// EXE_LS   | address calculation for LW/SW
// MEM      | data memory access, held until dmem_ready
// WB_AL    | ALU result write-back
// WB_LD    | load data write-back
// HALT     | stopped until reset
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);
    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;

    logic [5:0]  op6;
    op_class_e   cls;
    dec_t        dec;
    logic        is_sw;

    logic imem_req, dmem_req, ir_wre, pc_wre, reg_wre, db_src, mem_rw;
    logic illegal;
    logic [1:0] pc_src;
    logic dec_valid;

    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    assign op6   = op_q[5:0];
    assign cls   = op_class(op6);
    assign dec   = decode_op(op6);
    assign is_sw = (op6 == OP_SW);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_wre   = 1'b0;
        pc_wre   = 1'b0;
        reg_wre  = 1'b0;
        db_src   = 1'b0;
        mem_rw   = 1'b0;
        illegal  = 1'b0;
        pc_src   = PC_SEQ;
        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_wre  = 1'b1;
                    op_d    = bus.opCode;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                case (cls)
                    CLS_AL:   state_d = S_EXE_AL;
                    CLS_BR:   state_d = S_EXE_BR;
                    CLS_LS:   state_d = S_EXE_LS;
                    CLS_HALT: state_d = S_HALT;
                    CLS_J: begin
                        pc_wre  = 1'b1;
                        pc_src  = PC_JMP;
                        state_d = S_IF;
                    end
                    default: begin
                        // undefined opcode retires as a NOP
                        illegal = 1'b1;
                        pc_wre  = 1'b1;
                        state_d = S_IF;
                    end
                endcase
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL: begin
                reg_wre = 1'b1;
                pc_wre  = 1'b1;
                state_d = S_IF;
            end
            S_EXE_BR: begin
                pc_wre  = 1'b1;
                pc_src  = bus.zero ? PC_BR : PC_SEQ;
                state_d = S_IF;
            end
            S_EXE_LS: state_d = S_MEM;
            S_MEM: begin
                dmem_req = 1'b1;
                mem_rw   = is_sw;
                if (bus.dmem_ready) begin
                    if (is_sw) begin
                        pc_wre  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB_LD;
                    end
                end
            end
            S_WB_LD: begin
                reg_wre = 1'b1;
                db_src  = 1'b1;
                pc_wre  = 1'b1;
                state_d = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign dec_valid = (state_q != S_IF) && (state_q != S_HALT);

    // State is IF during reset, so everything is qualified with ~reset to
    // keep requests and enables quiet until reset is released.
    assign bus.imem_req   = imem_req & ~reset;
    assign bus.dmem_req   = dmem_req & ~reset;
    assign bus.IRWre      = ir_wre   & ~reset;
    assign bus.PCWre      = pc_wre   & ~reset;
    assign bus.RegWre     = reg_wre  & ~reset;
    assign bus.DBDataSrc  = db_src   & ~reset;
    assign bus.DataMemRW  = mem_rw   & ~reset;
    assign bus.PCSrc      = reset ? PC_SEQ : pc_src;
    assign bus.illegal_op = illegal  & ~reset;
    assign bus.halted     = (state_q == S_HALT) & ~reset;
    assign bus.state      = state_q;

    assign bus.ALUOp   = dec_valid ? dec.alu_op    : 3'd0;
    assign bus.ALUSrcB = dec_valid & dec.alu_src_b;
    assign bus.ExtSel  = dec_valid & dec.ext_sel;
    assign bus.RegOut  = dec_valid & dec.reg_out;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (state_q != S_HALT),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_wre),
        .count (instr_cnt)
    );

    assign bus.cycle_cnt = cycle_cnt;
    assign bus.instr_cnt = instr_cnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic reset2;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.OP_W(6), .CNT_W(32)) ifa ();
   multicycle_ctrl_if #(.OP_W(6), .CNT_W(4))  ifb ();

   multicycle_ctrl #(.OP_W(6), .CNT_W(32)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.master)
   );

   multicycle_ctrl #(.OP_W(6), .CNT_W(4)) dut_b (
      .clk   (clk),
      .reset (reset2),
      .bus   (ifb.master)
   );

   task automatic chk(input string tag, input bit ok);
      total++;
      if (!ok) begin
         bad++;
         $error("FAIL %s", tag);
      end
   endtask

   initial begin
      reset  = 1'b1;
      reset2 = 1'b1;
      ifa.opCode     = 6'd0;
      ifa.zero       = 1'b0;
      ifa.imem_ready = 1'b1;
      ifa.dmem_ready = 1'b1;
      ifb.opCode     = OP_J;
      ifb.zero       = 1'b0;
      ifb.imem_ready = 1'b1;
      ifb.dmem_ready = 1'b1;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_state", ifa.state === S_IF);
      chk("rst_imem_req", ifa.imem_req === 1'b0);
      chk("rst_irwre", ifa.IRWre === 1'b0);
      chk("rst_cycle", ifa.cycle_cnt === 32'd0);
      chk("rst_halted", ifa.halted === 1'b0);

      @(negedge clk);
      reset = 1'b0; reset2 = 1'b0;
      ifa.opCode = OP_ADD;
      #1;
      chk("add_if_state", ifa.state === S_IF);
      chk("add_if_imem_req", ifa.imem_req === 1'b1);
      chk("add_if_irwre", ifa.IRWre === 1'b1);
      chk("add_if_cycle", ifa.cycle_cnt === 32'd0);
      @(negedge clk); #1;
      chk("add_id_state", ifa.state === S_ID);
      chk("add_id_pcwre", ifa.PCWre === 1'b0);
      chk("add_id_aluop", ifa.ALUOp === ALU_ADD);
      chk("add_id_regout", ifa.RegOut === 1'b1);
      chk("add_id_imem_req", ifa.imem_req === 1'b0);
      @(negedge clk); #1;
      chk("add_exe_state", ifa.state === S_EXE_AL);
      chk("add_exe_pcwre", ifa.PCWre === 1'b0);
      chk("add_exe_regwre", ifa.RegWre === 1'b0);
      @(negedge clk); #1;
      chk("add_wb_state", ifa.state === S_WB_AL);
      chk("add_wb_regwre", ifa.RegWre === 1'b1);
      chk("add_wb_pcwre", ifa.PCWre === 1'b1);
      chk("add_wb_dbsrc", ifa.DBDataSrc === 1'b0);
      chk("add_wb_pcsrc", ifa.PCSrc === PC_SEQ);
      chk("add_wb_instr", ifa.instr_cnt === 32'd0);
      @(negedge clk);
      ifa.opCode = OP_LW;
      #1;
      chk("lw_if_state", ifa.state === S_IF);
      chk("add_instr_cnt", ifa.instr_cnt === 32'd1);
      chk("c5_cycle_cnt", ifa.cycle_cnt === 32'd4);
      chk("lw_if_regwre", ifa.RegWre === 1'b0);
      @(negedge clk);
      ifa.dmem_ready = 1'b0;
      #1;
      chk("lw_id_alusrcb", ifa.ALUSrcB === 1'b1);
      chk("lw_id_extsel", ifa.ExtSel === 1'b1);
      chk("lw_id_regout", ifa.RegOut === 1'b0);
      @(negedge clk); #1;
      chk("lw_exe_state", ifa.state === S_EXE_LS);
      chk("lw_exe_dmem_req", ifa.dmem_req === 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("lw_mem_wait_state", ifa.state === S_MEM);
         chk("lw_mem_wait_req", ifa.dmem_req === 1'b1);
         chk("lw_mem_wait_rw", ifa.DataMemRW === 1'b0);
         chk("lw_mem_wait_pcwre", ifa.PCWre === 1'b0);
      end
      @(negedge clk);
      ifa.dmem_ready = 1'b1;
      #1;
      chk("lw_mem_done_state", ifa.state === S_MEM);
      chk("lw_mem_done_req", ifa.dmem_req === 1'b1);
      chk("lw_mem_done_rw", ifa.DataMemRW === 1'b0);
      @(negedge clk); #1;
      chk("lw_wb_state", ifa.state === S_WB_LD);
      chk("lw_wb_regwre", ifa.RegWre === 1'b1);
      chk("lw_wb_dbsrc", ifa.DBDataSrc === 1'b1);
      chk("lw_wb_pcwre", ifa.PCWre === 1'b1);
      @(negedge clk);
      ifa.imem_ready = 1'b0;
      #1;
      chk("stall_state", ifa.state === S_IF);
      chk("stall_imem_req", ifa.imem_req === 1'b1);
      chk("stall_irwre", ifa.IRWre === 1'b0);
      chk("lw_instr_cnt", ifa.instr_cnt === 32'd2);
      chk("c13_cycle_cnt", ifa.cycle_cnt === 32'd12);
      @(negedge clk);
      ifa.imem_ready = 1'b1;
      ifa.opCode = OP_BEQ;
      #1;
      chk("beq_if_state", ifa.state === S_IF);
      chk("beq_if_irwre", ifa.IRWre === 1'b1);
      @(negedge clk);
      ifa.zero = 1'b1;
      #1;
      chk("beq_id_aluop", ifa.ALUOp === ALU_SUB);
      @(negedge clk); #1;
      chk("beq_t_state", ifa.state === S_EXE_BR);
      chk("beq_t_pcwre", ifa.PCWre === 1'b1);
      chk("beq_t_pcsrc", ifa.PCSrc === PC_BR);
      @(negedge clk); #1;
      chk("beq2_if_state", ifa.state === S_IF);
      @(negedge clk); #1;
      chk("beq2_id_state", ifa.state === S_ID);
      @(negedge clk);
      ifa.zero = 1'b0;
      #1;
      chk("beq_nt_state", ifa.state === S_EXE_BR);
      chk("beq_nt_pcwre", ifa.PCWre === 1'b1);
      chk("beq_nt_pcsrc", ifa.PCSrc === PC_SEQ);
      @(negedge clk);
      ifa.opCode = 6'b101010;
      #1;
      chk("ill_if_flag", ifa.illegal_op === 1'b0);
      @(negedge clk); #1;
      chk("ill_id_state", ifa.state === S_ID);
      chk("ill_id_flag", ifa.illegal_op === 1'b1);
      chk("ill_id_pcwre", ifa.PCWre === 1'b1);
      chk("ill_id_pcsrc", ifa.PCSrc === PC_SEQ);
      @(negedge clk);
      ifa.opCode = OP_J;
      #1;
      chk("ill_back_state", ifa.state === S_IF);
      chk("ill_back_flag", ifa.illegal_op === 1'b0);
      @(negedge clk); #1;
      chk("j_id_pcwre", ifa.PCWre === 1'b1);
      chk("j_id_pcsrc", ifa.PCSrc === PC_JMP);
      @(negedge clk);
      ifa.opCode = OP_SW;
      #1;
      chk("c24_instr_cnt", ifa.instr_cnt === 32'd6);
      chk("c24_cycle_cnt", ifa.cycle_cnt === 32'd23);
      repeat (2) @(negedge clk);
      @(negedge clk);
      ifa.dmem_ready = 1'b0;
      #1;
      chk("sw_mem_state", ifa.state === S_MEM);
      chk("sw_mem_req", ifa.dmem_req === 1'b1);
      chk("sw_mem_rw", ifa.DataMemRW === 1'b1);
      reset = 1'b1;
      #1;
      chk("midrst_state", ifa.state === S_IF);
      chk("midrst_dmem_req", ifa.dmem_req === 1'b0);
      chk("midrst_rw", ifa.DataMemRW === 1'b0);
      chk("midrst_imem_req", ifa.imem_req === 1'b0);
      chk("midrst_cycle", ifa.cycle_cnt === 32'd0);
      chk("midrst_instr", ifa.instr_cnt === 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ifa.opCode = OP_HALT;
      ifa.dmem_ready = 1'b1;
      #1;
      chk("post_rst_imem_req", ifa.imem_req === 1'b1);
      chk("post_rst_state", ifa.state === S_IF);
      @(negedge clk); #1;
      chk("halt_id_state", ifa.state === S_ID);
      @(negedge clk); #1;
      chk("halt_state", ifa.state === S_HALT);
      chk("halt_flag", ifa.halted === 1'b1);
      chk("halt_imem_req", ifa.imem_req === 1'b0);
      chk("halt_pcwre", ifa.PCWre === 1'b0);
      chk("halt_cycle", ifa.cycle_cnt === 32'd2);
      repeat (5) @(negedge clk);
      #1;
      chk("halt_sticky_state", ifa.state === S_HALT);
      chk("halt_sticky_flag", ifa.halted === 1'b1);
      chk("halt_cycle_frozen", ifa.cycle_cnt === 32'd2);
      chk("halt_instr_frozen", ifa.instr_cnt === 32'd0);

      repeat (10) @(negedge clk);
      #1;
      chk("sat_instr", ifb.instr_cnt === 4'd15);
      chk("sat_cycle", ifb.cycle_cnt === 4'd15);
      repeat (3) @(negedge clk);
      #1;
      chk("sat_instr_hold", ifb.instr_cnt === 4'd15);
      chk("sat_cycle_hold", ifb.cycle_cnt === 4'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
